// File: rtl/rv0_fwb.sv
`default_nettype none
// ============================================================================
// Module  : rv0_fwb
// Purpose : FP writeback arbiter (FPU vs LSU FP-load) with a pending-register
//           scoreboard that stalls FP issue on RAW/WAW hazards. Optional
//           macro RV0_FWB_BYPASS_EN enables FRF write-through hazard relief.
// Revision: 1.0 - initial release
// ============================================================================
module rv0_fwb #(
    parameter int FLEN    = 64,
    parameter int AGE_MAX = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            iss_vld_i,
    input  logic [4:0]      iss_rd_i,
    input  logic [14:0]     iss_rs_i,
    input  logic [2:0]      iss_rs_use_i,
    output logic            iss_stall_o,
    input  logic            fpu_vld_i,
    output logic            fpu_rdy_o,
    input  logic [4:0]      fpu_rd_i,
    input  logic [FLEN-1:0] fpu_data_i,
    input  logic [4:0]      fpu_fflags_i,
    input  logic            lsu_vld_i,
    output logic            lsu_rdy_o,
    input  logic [4:0]      lsu_rd_i,
    input  logic [FLEN-1:0] lsu_data_i,
    output logic            frf_we_o,
    output logic [4:0]      frf_waddr_o,
    output logic [FLEN-1:0] frf_wdata_o,
    output logic            fflags_vld_o,
    output logic [4:0]      fflags_o,
    output logic [31:0]     busy_o
);

    logic [2:0]      r_age;
    logic            r_frf_we;
    logic [4:0]      r_frf_waddr;
    logic [FLEN-1:0] r_frf_wdata;
    logic            r_fflags_vld;
    logic [4:0]      r_fflags;
    logic [31:0]     r_busy;

    logic            w_age_full;
    logic            w_fpu_gnt;
    logic            w_lsu_gnt;
    logic [31:0]     w_wr_mask;
    logic [31:0]     w_set_mask;
    logic [31:0]     w_busy_eff;
    logic            w_hit;
    logic            w_stall;

    // LSU has priority unless the FPU has been starved AGE_MAX cycles in a row.
    assign w_age_full = (r_age == 3'(AGE_MAX));
    assign w_fpu_gnt  = fpu_vld_i && (!lsu_vld_i || w_age_full);
    assign w_lsu_gnt  = lsu_vld_i && !w_fpu_gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_age <= 3'd0;
        end else if (!fpu_vld_i || w_fpu_gnt) begin
            r_age <= 3'd0;
        end else begin
            r_age <= r_age + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frf_we     <= 1'b0;
            r_frf_waddr  <= 5'd0;
            r_frf_wdata  <= '0;
            r_fflags_vld <= 1'b0;
            r_fflags     <= 5'd0;
        end else begin
            r_frf_we     <= w_fpu_gnt || w_lsu_gnt;
            r_fflags_vld <= w_fpu_gnt;
            r_fflags     <= w_fpu_gnt ? fpu_fflags_i : 5'd0;
            if (w_fpu_gnt) begin
                r_frf_waddr <= fpu_rd_i;
                r_frf_wdata <= fpu_data_i;
            end else if (w_lsu_gnt) begin
                r_frf_waddr <= lsu_rd_i;
                r_frf_wdata <= lsu_data_i;
            end
        end
    end

    assign w_wr_mask = r_frf_we ? (32'd1 << r_frf_waddr) : 32'd0;

`ifdef RV0_FWB_BYPASS_EN
    // The register being written this cycle is readable via FRF write-through.
    assign w_busy_eff = r_busy & ~w_wr_mask;
`else
    assign w_busy_eff = r_busy;
`endif

    always_comb begin
        w_hit = w_busy_eff[iss_rd_i];
        for (int k = 0; k < 3; k++) begin
            if (iss_rs_use_i[k] && w_busy_eff[iss_rs_i[5*k +: 5]]) begin
                w_hit = 1'b1;
            end
        end
        w_stall = iss_vld_i && w_hit;
    end

    assign w_set_mask = (iss_vld_i && !w_stall) ? (32'd1 << iss_rd_i) : 32'd0;

    // Clear first, then set, so a same-cycle set of the written rd survives.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 32'd0;
        end else begin
            r_busy <= (r_busy & ~w_wr_mask) | w_set_mask;
        end
    end

    assign iss_stall_o  = w_stall;
    assign fpu_rdy_o    = w_fpu_gnt;
    assign lsu_rdy_o    = w_lsu_gnt;
    assign frf_we_o     = r_frf_we;
    assign frf_waddr_o  = r_frf_waddr;
    assign frf_wdata_o  = r_frf_wdata;
    assign fflags_vld_o = r_fflags_vld;
    assign fflags_o     = r_fflags;
    assign busy_o       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_rv0_fwb.sv
`default_nettype none
// ============================================================================
// Module  : tb_rv0_fwb
// Purpose : Self-checking bench for rv0_fwb (directed scenarios plus a
//           randomized run against a behavioural model).
// Revision: 1.0 - initial release
// ============================================================================
module tb_rv0_fwb;
    localparam int FLEN    = 64;
    localparam int AGE_MAX = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            iss_vld_i;
    logic [4:0]      iss_rd_i;
    logic [14:0]     iss_rs_i;
    logic [2:0]      iss_rs_use_i;
    logic            iss_stall_o;
    logic            fpu_vld_i;
    logic            fpu_rdy_o;
    logic [4:0]      fpu_rd_i;
    logic [FLEN-1:0] fpu_data_i;
    logic [4:0]      fpu_fflags_i;
    logic            lsu_vld_i;
    logic            lsu_rdy_o;
    logic [4:0]      lsu_rd_i;
    logic [FLEN-1:0] lsu_data_i;
    logic            frf_we_o;
    logic [4:0]      frf_waddr_o;
    logic [FLEN-1:0] frf_wdata_o;
    logic            fflags_vld_o;
    logic [4:0]      fflags_o;
    logic [31:0]     busy_o;

    int checks   = 0;
    int failures = 0;

`ifdef RV0_FWB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    rv0_fwb #(.FLEN(FLEN), .AGE_MAX(AGE_MAX)) dut (
        .clk(clk), .rst(rst),
        .iss_vld_i(iss_vld_i), .iss_rd_i(iss_rd_i), .iss_rs_i(iss_rs_i),
        .iss_rs_use_i(iss_rs_use_i), .iss_stall_o(iss_stall_o),
        .fpu_vld_i(fpu_vld_i), .fpu_rdy_o(fpu_rdy_o), .fpu_rd_i(fpu_rd_i),
        .fpu_data_i(fpu_data_i), .fpu_fflags_i(fpu_fflags_i),
        .lsu_vld_i(lsu_vld_i), .lsu_rdy_o(lsu_rdy_o), .lsu_rd_i(lsu_rd_i),
        .lsu_data_i(lsu_data_i),
        .frf_we_o(frf_we_o), .frf_waddr_o(frf_waddr_o), .frf_wdata_o(frf_wdata_o),
        .fflags_vld_o(fflags_vld_o), .fflags_o(fflags_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic idle();
        iss_vld_i = 0; iss_rd_i = 0; iss_rs_i = 0; iss_rs_use_i = 0;
        fpu_vld_i = 0; fpu_rd_i = 0; fpu_data_i = 0; fpu_fflags_i = 0;
        lsu_vld_i = 0; lsu_rd_i = 0; lsu_data_i = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks += 6;
        if (frf_we_o !== 1'b0) begin failures++; $display("FAIL reset_we act=%0b exp=0", frf_we_o); end
        if (frf_waddr_o !== 5'd0) begin failures++; $display("FAIL reset_waddr act=%0d exp=0", frf_waddr_o); end
        if (frf_wdata_o !== '0) begin failures++; $display("FAIL reset_wdata act=%h exp=0", frf_wdata_o); end
        if (fflags_vld_o !== 1'b0) begin failures++; $display("FAIL reset_fvld act=%0b exp=0", fflags_vld_o); end
        if (fflags_o !== 5'd0) begin failures++; $display("FAIL reset_fflags act=%h exp=0", fflags_o); end
        if (busy_o !== 32'd0) begin failures++; $display("FAIL reset_busy act=%h exp=0", busy_o); end
    endtask

    task automatic test_single_fpu();
        fpu_vld_i = 1; fpu_rd_i = 5; fpu_data_i = 64'h3FF0000000000000; fpu_fflags_i = 5'h01;
        #1;
        checks++;
        if (fpu_rdy_o !== 1'b1) begin failures++; $display("FAIL single_rdy act=%0b exp=1", fpu_rdy_o); end
        tick();
        idle();
        checks += 5;
        if (frf_we_o !== 1'b1) begin failures++; $display("FAIL single_we act=%0b exp=1", frf_we_o); end
        if (frf_waddr_o !== 5'd5) begin failures++; $display("FAIL single_waddr act=%0d exp=5", frf_waddr_o); end
        if (frf_wdata_o !== 64'h3FF0000000000000) begin failures++; $display("FAIL single_wdata act=%h exp=3ff0000000000000", frf_wdata_o); end
        if (fflags_vld_o !== 1'b1) begin failures++; $display("FAIL single_fvld act=%0b exp=1", fflags_vld_o); end
        if (fflags_o !== 5'h01) begin failures++; $display("FAIL single_fflags act=%h exp=01", fflags_o); end
        tick();
        checks++;
        if (frf_we_o !== 1'b0) begin failures++; $display("FAIL single_pulse act=%0b exp=0", frf_we_o); end
    endtask

    task automatic test_age_pattern();
        fpu_vld_i = 1; fpu_rd_i = 2; fpu_data_i = 64'hAAAA; fpu_fflags_i = 5'h10;
        lsu_vld_i = 1; lsu_rd_i = 1; lsu_data_i = 64'h5555;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) begin
                checks += 2;
                if (frf_waddr_o !== (((i - 1) % 4 == 3) ? 5'd2 : 5'd1)) begin
                    failures++; $display("FAIL age_waddr cyc=%0d act=%0d", i, frf_waddr_o);
                end
                if (fflags_o !== (((i - 1) % 4 == 3) ? 5'h10 : 5'h00)) begin
                    failures++; $display("FAIL age_fflags cyc=%0d act=%h", i, fflags_o);
                end
            end
            #1;
            checks += 2;
            if (fpu_rdy_o !== (i % 4 == 3)) begin
                failures++; $display("FAIL age_fpu_rdy cyc=%0d act=%0b exp=%0b", i, fpu_rdy_o, (i % 4 == 3));
            end
            if (lsu_rdy_o !== (i % 4 != 3)) begin
                failures++; $display("FAIL age_lsu_rdy cyc=%0d act=%0b exp=%0b", i, lsu_rdy_o, (i % 4 != 3));
            end
            tick();
        end
        idle();
        tick();
    endtask

    task automatic test_raw_stall();
        do_reset();
        iss_vld_i = 1; iss_rd_i = 7;
        #1;
        checks++;
        if (iss_stall_o !== 1'b0) begin failures++; $display("FAIL raw_first act=%0b exp=0", iss_stall_o); end
        tick();
        iss_rd_i = 8; iss_rs_i = {5'd0, 5'd0, 5'd7}; iss_rs_use_i = 3'b001;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (iss_stall_o !== 1'b1) begin failures++; $display("FAIL raw_hold cyc=%0d act=%0b exp=1", i, iss_stall_o); end
            tick();
        end
        fpu_vld_i = 1; fpu_rd_i = 7; fpu_data_i = 64'h1234;
        #1;
        checks++;
        if (iss_stall_o !== 1'b1) begin failures++; $display("FAIL raw_accept_cyc act=%0b exp=1", iss_stall_o); end
        tick();
        fpu_vld_i = 0;
        #1;
        checks++;
        if (iss_stall_o !== !BYP) begin failures++; $display("FAIL raw_write_cyc act=%0b exp=%0b", iss_stall_o, !BYP); end
        tick();
        if (BYP) iss_vld_i = 0;
        #1;
        checks++;
        if (iss_stall_o !== 1'b0) begin failures++; $display("FAIL raw_after act=%0b exp=0", iss_stall_o); end
        tick();
        idle();
    endtask

    task automatic test_set_clear_same();
        do_reset();
        fpu_vld_i = 1; fpu_rd_i = 3; fpu_data_i = 64'h77;
        tick();
        fpu_vld_i = 0;
        iss_vld_i = 1; iss_rd_i = 3;
        #1;
        checks += 2;
        if (frf_we_o !== 1'b1 || frf_waddr_o !== 5'd3) begin
            failures++; $display("FAIL sc_write act_we=%0b act_addr=%0d exp=1/3", frf_we_o, frf_waddr_o);
        end
        if (iss_stall_o !== 1'b0) begin failures++; $display("FAIL sc_stall act=%0b exp=0", iss_stall_o); end
        tick();
        idle();
        checks++;
        if (busy_o[3] !== 1'b1) begin failures++; $display("FAIL sc_busy3 act=%0b exp=1", busy_o[3]); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int r = 0; r < 16; r++) begin
            iss_vld_i = 1; iss_rd_i = 5'(r);
            tick();
        end
        idle();
        checks++;
        if (busy_o !== 32'h0000FFFF) begin failures++; $display("FAIL mid_busy act=%h exp=0000ffff", busy_o); end
        fpu_vld_i = 1; fpu_rd_i = 4; fpu_data_i = 64'h99;
        rst = 1;
        #1;
        checks++;
        if (fpu_rdy_o !== 1'b1) begin failures++; $display("FAIL mid_rdy act=%0b exp=1", fpu_rdy_o); end
        tick();
        rst = 0;
        idle();
        checks += 2;
        if (busy_o !== 32'd0) begin failures++; $display("FAIL mid_busy_clr act=%h exp=0", busy_o); end
        if (frf_we_o !== 1'b0) begin failures++; $display("FAIL mid_we act=%0b exp=0", frf_we_o); end
    endtask

    task automatic test_random();
        logic            m_we, m_fv;
        logic [4:0]      m_waddr, m_ff;
        logic [FLEN-1:0] m_wdata;
        logic [31:0]     m_busy;
        int              denials;
        bit              fg, lg, stall, prev_fg, prev_lg;
        logic [31:0]     eff;
        do_reset();
        m_we = 0; m_fv = 0; m_waddr = 0; m_ff = 0; m_wdata = 0; m_busy = 0;
        denials = 0; prev_fg = 0; prev_lg = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            checks += 4;
            if (frf_we_o !== m_we || (m_we && (frf_waddr_o !== m_waddr || frf_wdata_o !== m_wdata))) begin
                failures++; $display("FAIL rnd_write cyc=%0d act=%0b/%0d/%h exp=%0b/%0d/%h",
                                     cyc, frf_we_o, frf_waddr_o, frf_wdata_o, m_we, m_waddr, m_wdata);
            end
            if (fflags_vld_o !== m_fv || fflags_o !== m_ff) begin
                failures++; $display("FAIL rnd_fflags cyc=%0d act=%0b/%h exp=%0b/%h", cyc, fflags_vld_o, fflags_o, m_fv, m_ff);
            end
            if (busy_o !== m_busy) begin
                failures++; $display("FAIL rnd_busy cyc=%0d act=%h exp=%h", cyc, busy_o, m_busy);
            end
            // Sources keep their transaction until it has been accepted.
            if (!fpu_vld_i || prev_fg) begin
                fpu_vld_i = ($urandom_range(0, 3) != 0);
                fpu_rd_i = 5'($urandom_range(0, 7));
                fpu_data_i = {$urandom(), $urandom()};
                fpu_fflags_i = 5'($urandom());
            end
            if (!lsu_vld_i || prev_lg) begin
                lsu_vld_i = ($urandom_range(0, 2) != 0);
                lsu_rd_i = 5'($urandom_range(0, 7));
                lsu_data_i = {$urandom(), $urandom()};
            end
            iss_vld_i = $urandom_range(0, 1);
            iss_rd_i = 5'($urandom_range(0, 7));
            iss_rs_i = {5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15))};
            iss_rs_use_i = 3'($urandom());
            #1;
            fg = fpu_vld_i && (!lsu_vld_i || denials == AGE_MAX);
            lg = lsu_vld_i && !fg;
            eff = m_busy;
            if (BYP && m_we) eff[m_waddr] = 1'b0;
            stall = iss_vld_i && (eff[iss_rd_i] ||
                    (iss_rs_use_i[0] && eff[iss_rs_i[4:0]]) ||
                    (iss_rs_use_i[1] && eff[iss_rs_i[9:5]]) ||
                    (iss_rs_use_i[2] && eff[iss_rs_i[14:10]]));
            checks += 3;
            if (fpu_rdy_o !== fg) begin failures++; $display("FAIL rnd_fpu_rdy cyc=%0d act=%0b exp=%0b", cyc, fpu_rdy_o, fg); end
            if (lsu_rdy_o !== lg) begin failures++; $display("FAIL rnd_lsu_rdy cyc=%0d act=%0b exp=%0b", cyc, lsu_rdy_o, lg); end
            if (iss_stall_o !== stall) begin failures++; $display("FAIL rnd_stall cyc=%0d act=%0b exp=%0b", cyc, iss_stall_o, stall); end
            if (m_we) m_busy[m_waddr] = 1'b0;
            if (iss_vld_i && !stall) m_busy[iss_rd_i] = 1'b1;
            denials = (fpu_vld_i && !fg) ? denials + 1 : 0;
            m_we = fg || lg;
            m_fv = fg;
            m_ff = fg ? fpu_fflags_i : 5'd0;
            if (fg) begin m_waddr = fpu_rd_i; m_wdata = fpu_data_i; end
            else if (lg) begin m_waddr = lsu_rd_i; m_wdata = lsu_data_i; end
            prev_fg = fg; prev_lg = lg;
            tick();
        end
        idle();
    endtask

    initial begin
        rst = 1;
        idle();
        @(negedge clk);
        test_reset();
        test_single_fpu();
        test_age_pattern();
        test_raw_stall();
        test_set_clear_same();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
